// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: host-transmit FSM encoding, frame length and
// well-known keyboard command bytes.
package ps2_defs;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    DONE      = 3'd6,
    ERR       = 3'd7
  } ps2_state_e;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 CLOCK and DATA pads plus a registered
// falling-edge detector on CLOCK (fall is seen 3 system clocks after the pad).
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_fall
);

  logic r_clk_meta;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_data_meta;
  logic r_data_sync;
  logic r_fall;

  // Idle PS/2 lines are high, so the flops reset to 1 to avoid a false fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
      r_fall      <= 1'b0;
    end else begin
      r_clk_meta  <= i_ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= i_ps2_data;
      r_data_sync <= r_data_meta;
      r_fall      <= r_clk_prev & ~r_clk_sync;
    end
  end

  assign o_clk_sync  = r_clk_sync;
  assign o_data_sync = r_data_sync;
  assign o_fall      = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte out on device clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iSend,
  input  logic       iPS2_CLOCK,
  input  logic       iPS2_DATA,
  output logic       oPS2_CLOCK_OE,
  output logic       oPS2_DATA_OE,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  output logic [2:0] oState
);

  import ps2_defs::*;

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       PARITY_IDX = 4'(FRAME_BITS - 3);

  ps2_state_e       r_state;
  ps2_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [7:0]       r_data;
  logic             r_parity;
  logic             r_data_oe;

  logic       w_clk_sync;
  logic       w_data_sync;
  logic       w_fall;
  logic       w_timeout;
  logic       w_inh_last;
  logic [3:0] w_next_idx;
  logic       w_next_bit;

  ps2_line_sync u_sync (
    .i_clk       (Clock),
    .i_rst_n     (Reset),
    .i_ps2_clk   (iPS2_CLOCK),
    .i_ps2_data  (iPS2_DATA),
    .o_clk_sync  (w_clk_sync),
    .o_data_sync (w_data_sync),
    .o_fall      (w_fall)
  );

  assign w_timeout  = (r_cnt == TO_LAST);
  assign w_inh_last = (r_cnt == INH_LAST);
  assign w_next_idx = r_bit + 4'd1;

  // Frame bit driven after the next fall: data LSB first, parity, then stop.
  always_comb begin
    w_next_bit = 1'b1;
    if (w_next_idx < 4'd8)
      w_next_bit = r_data[w_next_idx[2:0]];
    else if (w_next_idx == PARITY_IDX)
      w_next_bit = r_parity;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (iSend) w_next = INHIBIT;
      INHIBIT:   if (w_inh_last) w_next = REQ;
      REQ: begin
        if (w_timeout)   w_next = ERR;
        else if (w_fall) w_next = SEND;
      end
      SEND: begin
        if (w_timeout)                          w_next = ERR;
        else if (w_fall && r_bit == PARITY_IDX) w_next = ACK;
      end
      ACK: begin
        if (w_timeout)   w_next = ERR;
        else if (w_fall) w_next = w_data_sync ? ERR : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (w_timeout)                      w_next = ERR;
        else if (w_clk_sync && w_data_sync) w_next = DONE;
      end
      DONE:      w_next = IDLE;
      ERR:       w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_bit     <= '0;
          r_data_oe <= 1'b0;
          if (iSend) begin
            r_data   <= iData;
            r_parity <= odd_parity(iData);
          end
        end
        INHIBIT: r_cnt <= w_inh_last ? '0 : r_cnt + 1'b1;
        REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_fall) r_data_oe <= ~r_data[0];
        end
        SEND: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_fall) begin
            r_bit     <= w_next_idx;
            r_data_oe <= ~w_next_bit;
          end
        end
        ACK: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_fall) r_bit <= w_next_idx;
        end
        WAIT_IDLE: r_cnt <= r_cnt + 1'b1;
        default: begin
          r_cnt     <= '0;
          r_data_oe <= 1'b0;
        end
      endcase
    end
  end

  // Start bit goes on DATA during the last inhibit cycle, before CLOCK release.
  assign oPS2_CLOCK_OE = (r_state == INHIBIT);
  assign oPS2_DATA_OE  = ((r_state == INHIBIT) && w_inh_last) ||
                         (r_state == REQ) ||
                         ((r_state == SEND) && r_data_oe);
  assign oBusy  = (r_state != IDLE);
  assign oDone  = (r_state == DONE);
  assign oError = (r_state == ERR);
  assign oState = r_state;

endmodule
